mac_acc_seq: RTL and testbench

- Bit-serial accumulator directly downstream of the bit-serial multiplier stage in the MAC datapath.
- Consumes the LSB-first serial product stream one bit per cycle.
- Adds each W-bit product frame into a W-bit accumulator with a 1-bit serial adder.
- After K frames, presents the dot-product result in parallel behind a valid/ready handshake.

---
 rtl/mac_acc_seq.sv | 182 ++++++++++++++++++
 tb/tb_mac_acc_seq.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_acc_seq.sv
// mac_acc_seq: bit-serial dot-product accumulator.
// Consumes LSB-first W-bit product frames one bit per cycle, adds each frame
// into a W-bit rotating accumulator through a 1-bit serial adder, and after K
// frames presents the sum in parallel behind a valid/ready handshake.
// Optional build macro MAC_ACC_SAT_EN: saturate the result to all ones on the
// first frame carry-out instead of wrapping modulo 2^W.
module mac_acc_seq #(
    parameter int W = 16,
    parameter int K = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_bit,
    input  logic         in_valid,
    input  logic         in_first,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_ovf,
    output logic         err
);

    localparam int CNT_W = (W > 1) ? $clog2(W) : 1;
    localparam int FRM_W = (K > 1) ? $clog2(K) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(W - 1);
    localparam logic [FRM_W-1:0] LAST_FRM = FRM_W'(K - 1);

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [W-1:0]     acc;
    logic             carry;
    logic [CNT_W-1:0] bit_cnt;
    logic [FRM_W-1:0] frm_cnt;
    logic             ovf_r;
    logic             err_r;
`ifdef MAC_ACC_SAT_EN
    logic             sat_r;
`endif

    logic             accept;
    logic             take_bit;
    logic             restart;
    logic             last_bit;
    logic             last_frm;
    logic             drain;
    logic [CNT_W-1:0] bit_idx;
    logic             cin;
    logic             sum_bit;
    logic             cout;
    logic [W-1:0]     acc_rot;

    // Carry of a full adder: majority of the three inputs.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

`ifdef MAC_ACC_SAT_EN
    // Frame-end accumulator value: clamp to all ones when the frame overflowed.
    function automatic logic [W-1:0] sat_frame_end(input logic [W-1:0] rot,
                                                   input logic         ovf);
        return ovf ? {W{1'b1}} : rot;
    endfunction
`endif

    // Serial adder and bit/frame bookkeeping for the bit presented this cycle.
    always_comb begin
        accept   = in_valid && in_ready;
        // In SYNC only a frame start is consumed; everything else is noise.
        take_bit = accept && ((state == ACC) || in_first);
        // A frame start arriving mid-frame is a framing error.
        restart  = accept && (state == ACC) && in_first;
        // Any frame start is bit 0, and its carry chain starts clean.
        bit_idx  = in_first ? '0 : bit_cnt;
        cin      = in_first ? 1'b0 : carry;
        last_bit = take_bit && (bit_idx == LAST_BIT);
        last_frm = last_bit && (frm_cnt == LAST_FRM);
        drain    = (state == HOLD) && out_ready;
        sum_bit  = in_bit ^ acc[0] ^ cin;
        cout     = maj3(in_bit, acc[0], cin);
        // Rotate right, inserting the new sum bit at the top; after W bits the
        // accumulator is back in natural order.
        acc_rot        = acc >> 1;
        acc_rot[W-1]   = sum_bit;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SYNC;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            SYNC, ACC: begin
                if (last_frm) begin
                    state_nxt = HOLD;
                end else if (last_bit) begin
                    state_nxt = SYNC;
                end else if (take_bit) begin
                    state_nxt = ACC;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_nxt = SYNC;
                end
            end
            default: state_nxt = SYNC;
        endcase
    end

    // Handshake outputs; the result bus is forced to zero outside HOLD.
    always_comb begin
        in_ready  = (state != HOLD);
        out_valid = (state == HOLD);
        out_data  = (state == HOLD) ? acc : '0;
        out_ovf   = (state == HOLD) && ovf_r;
        err       = err_r;
    end

    // Accumulator, serial carry, counters and sticky flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            carry   <= 1'b0;
            bit_cnt <= '0;
            frm_cnt <= '0;
            ovf_r   <= 1'b0;
            err_r   <= 1'b0;
`ifdef MAC_ACC_SAT_EN
            sat_r   <= 1'b0;
`endif
        end else if (drain) begin
            // Result consumed: the next dot product starts from zero.
            acc   <= '0;
            ovf_r <= 1'b0;
`ifdef MAC_ACC_SAT_EN
            sat_r <= 1'b0;
`endif
        end else if (take_bit) begin
            if (restart) begin
                err_r <= 1'b1;
            end
            if (last_bit) begin
                bit_cnt <= '0;
                carry   <= 1'b0;
                frm_cnt <= last_frm ? '0 : frm_cnt + 1'b1;
                if (cout) begin
                    ovf_r <= 1'b1;
                end
            end else begin
                bit_cnt <= bit_idx + 1'b1;
                carry   <= cout;
            end
`ifdef MAC_ACC_SAT_EN
            // Once saturated the accumulator is frozen at all ones.
            if (!sat_r) begin
                acc <= last_bit ? sat_frame_end(acc_rot, cout) : acc_rot;
            end
            if (last_bit && cout) begin
                sat_r <= 1'b1;
            end
`else
            acc <= acc_rot;
`endif
        end
    end

endmodule

// File: tb/tb_mac_acc_seq.sv
// Testbench for mac_acc_seq (W=8, K=2): table of two-frame dot products
// (fixed and random) against a behavioural sum model, plus hand-written
// sequences for backpressure, idle noise, framing errors and async reset.
module tb_mac_acc_seq;

    localparam int W    = 8;
    localparam int K    = 2;
    localparam int MAXV = (1 << W) - 1;

    logic         clk;
    logic         rst;
    logic         in_bit;
    logic         in_valid;
    logic         in_first;
    logic         in_ready;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_ovf;
    logic         err;

    int n_checks = 0;
    int n_fail   = 0;

    mac_acc_seq #(.W(W), .K(K)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_bit    (in_bit),
        .in_valid  (in_valid),
        .in_first  (in_first),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ovf   (out_ovf),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int a;
        int b;
        int exp_d;
        bit exp_o;
        bit gap;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Unsigned sum of a list of frames, modulo 2^W or clamped when saturating.
    function automatic int model_sum(input int fa, input int fb, output bit ovf);
        int frames[2];
        int total;
        bit sat;
        frames = '{fa, fb};
        total  = 0;
        sat    = 1'b0;
        ovf    = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (!sat) begin
                total = total + frames[i];
                if (total > MAXV) begin
                    ovf = 1'b1;
`ifdef MAC_ACC_SAT_EN
                    sat   = 1'b1;
                    total = MAXV;
`else
                    total = total - (MAXV + 1);
`endif
                end
            end
        end
        return total;
    endfunction

    // Present one input cycle, then advance to just after the next rising edge.
    task automatic drive(input logic v, input logic f, input logic b);
        in_valid = v;
        in_first = f;
        in_bit   = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0);
    endtask

    // Send a W-bit frame LSB first, optionally with random idle gaps between bits.
    task automatic send_frame(input int value, input bit gap);
        logic [W-1:0] v;
        v = W'(value);
        for (int i = 0; i < W; i++) begin
            if (gap && i != 0) begin
                int n;
                n = $urandom_range(0, 2);
                for (int g = 0; g < n; g++) begin
                    drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                end
            end
            drive(1'b1, (i == 0), v[i]);
        end
        in_valid = 1'b0;
    endtask

    initial begin
        int  exp_d;
        bit  exp_o;
        logic [W-1:0] vv;

        rst       = 1'b1;
        in_bit    = 1'b0;
        in_valid  = 1'b0;
        in_first  = 1'b0;
        out_ready = 1'b1;

        // Fixed rows from the plan, then random rows with model expectations.
        vecs[0] = '{a: 5, b: 3, exp_d: 8, exp_o: 1'b0, gap: 1'b0};
`ifdef MAC_ACC_SAT_EN
        vecs[1] = '{a: 200, b: 100, exp_d: 255, exp_o: 1'b1, gap: 1'b0};
`else
        vecs[1] = '{a: 200, b: 100, exp_d: 44, exp_o: 1'b1, gap: 1'b0};
`endif
        vecs[2] = '{a: 255, b: 0, exp_d: 255, exp_o: 1'b0, gap: 1'b0};
        vecs[3] = '{a: 255, b: 1, exp_d: 0, exp_o: 1'b1, gap: 1'b0};
        for (int i = 4; i < 10; i++) begin
            vecs[i].a     = int'($urandom_range(0, MAXV));
            vecs[i].b     = int'($urandom_range(0, MAXV));
            vecs[i].exp_d = model_sum(vecs[i].a, vecs[i].b, vecs[i].exp_o);
            vecs[i].gap   = 1'b1;
        end

        // Reset state.
        #12;
        check("reset in_ready", in_ready, 1);
        check("reset out_valid", out_valid, 0);
        check("reset out_data", out_data, 0);
        check("reset out_ovf", out_ovf, 0);
        check("reset err", err, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Table-driven two-frame dot products with immediate consumer.
        for (int i = 0; i < 10; i++) begin
            out_ready = 1'b1;
            send_frame(vecs[i].a, vecs[i].gap);
            check($sformatf("vec%0d valid after frame1", i), out_valid, 0);
            send_frame(vecs[i].b, vecs[i].gap);
            check($sformatf("vec%0d out_valid", i), out_valid, 1);
            check($sformatf("vec%0d out_data", i), out_data, vecs[i].exp_d);
            check($sformatf("vec%0d out_ovf", i), out_ovf, vecs[i].exp_o);
            check($sformatf("vec%0d in_ready in hold", i), in_ready, 0);
            idle();
            check($sformatf("vec%0d valid one cycle", i), out_valid, 0);
            check($sformatf("vec%0d data cleared", i), out_data, 0);
        end

        // Backpressure: result stable while stalled, bits offered in HOLD ignored.
        out_ready = 1'b0;
        send_frame(10, 1'b0);
        send_frame(20, 1'b0);
        for (int c = 0; c < 5; c++) begin
            check("bp out_valid", out_valid, 1);
            check("bp out_data", out_data, 30);
            check("bp in_ready", in_ready, 0);
            drive(1'b1, 1'b1, 1'b1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp out_valid before handshake", out_valid, 1);
        idle();
        check("bp handshake drops valid", out_valid, 0);
        check("bp in_ready after handshake", in_ready, 1);
        send_frame(1, 1'b0);
        send_frame(2, 1'b0);
        check("bp next result", out_data, 3);
        idle();

        // Idle noise in SYNC is discarded.
        for (int c = 0; c < 3; c++) drive(1'b1, 1'b0, 1'b1);
        send_frame(7, 1'b0);
        send_frame(0, 1'b0);
        check("noise out_valid", out_valid, 1);
        check("noise out_data", out_data, 7);
        check("noise err", err, 0);
        idle();

        // Misplaced frame start at bit 4 (partial bits zero), then clean frame.
        for (int i = 0; i < 4; i++) drive(1'b1, (i == 0), 1'b0);
        vv = W'(37);
        drive(1'b1, 1'b1, vv[0]);
        check("misplaced err set", err, 1);
        for (int i = 1; i < W; i++) drive(1'b1, 1'b0, vv[i]);
        check("misplaced frame not final", out_valid, 0);
        send_frame(60, 1'b0);
        exp_d = model_sum(37, 60, exp_o);
        check("misplaced out_valid", out_valid, 1);
        check("misplaced out_data", out_data, exp_d);
        check("misplaced out_ovf", out_ovf, exp_o);
        idle();
        check("err sticky after handshake", err, 1);

        // Async reset mid-frame 2.
        send_frame(50, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b1, (i == 0), 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("rst mid err", err, 0);
        check("rst mid in_ready", in_ready, 1);
        check("rst mid out_valid", out_valid, 0);
        check("rst mid out_data", out_data, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        send_frame(1, 1'b0);
        send_frame(1, 1'b0);
        check("after rst out_valid", out_valid, 1);
        check("after rst out_data", out_data, 2);
        check("after rst out_ovf", out_ovf, 0);
        idle();

        // Async reset while holding an unconsumed result.
        out_ready = 1'b0;
        send_frame(9, 1'b0);
        send_frame(9, 1'b0);
        check("hold before rst", out_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        check("rst hold out_valid", out_valid, 0);
        check("rst hold out_data", out_data, 0);
        check("rst hold in_ready", in_ready, 1);
        rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
